datapath: RTL

- Accumulator datapath and data memory of the BIP-style processor.
- Sits directly downstream of the control unit and consumes its decoded strobes, SelA/SelB/Op selects and 11-bit operand.
- Holds the 16-bit accumulator, the add/sub ALU and a word-addressed data RAM.
- After every reset it sweeps the RAM to zero, then signals ready.

---
 rtl/datapath.sv | 137 +++++++++++++
 1 files changed

// File: rtl/datapath.sv
// Accumulator datapath and data memory of the BIP-style processor.
// After every reset the RAM is swept to zero (CLEAR); o_Ready then rises and
// the block executes the decoded strobes from the control unit (RUN).
module datapath #(
  parameter int NBITS_0 = 11,  // operand / data address width
  parameter int NBITS_D = 16   // data word and accumulator width
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [1:0]         i_SelA,
  input  logic               i_SelB,
  input  logic               i_WrAcc,
  input  logic               i_Op,
  input  logic               i_WrRam,
  input  logic               i_RdRam,
  input  logic [NBITS_0-1:0] i_Operand,
  output logic [NBITS_D-1:0] o_Acc,
  output logic               o_Ready
);

  localparam int DEPTH = 2 ** NBITS_0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SRC_RAM  = 2'b00,
    SRC_IMM  = 2'b01,
    SRC_ALU  = 2'b10,
    SRC_NONE = 2'b11
  } acc_src_e;

  state_e               state_q;
  logic [NBITS_0-1:0]   clr_addr_q;
  logic [NBITS_D-1:0]   acc_q;
  logic [NBITS_D-1:0]   acc_d;
  logic                 acc_load;
  logic                 ready_q;

  logic [NBITS_D-1:0]   mem [DEPTH];

  logic [NBITS_D-1:0]   imm;
  logic [NBITS_D-1:0]   rd;
  logic [NBITS_D-1:0]   opnd_b;
  logic [NBITS_D-1:0]   alu;

  logic                 mem_we;
  logic [NBITS_0-1:0]   mem_addr;
  logic [NBITS_D-1:0]   mem_wdata;

  // Operand decode, asynchronous RAM read, ALU and accumulator source mux.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it
    // unassigned; a missing default in always_comb infers a latch.
    imm      = {{(NBITS_D-NBITS_0){i_Operand[NBITS_0-1]}}, i_Operand};
    rd       = '0;
    acc_d    = acc_q;
    acc_load = 1'b0;

    // RAM contents are meaningless while the sweep runs, so reads return 0.
    if (state_q == RUN && i_RdRam) begin
      rd = mem[i_Operand];
    end

    opnd_b = i_SelB ? imm : rd;
    alu    = i_Op ? (acc_q - opnd_b) : (acc_q + opnd_b);

    case (acc_src_e'(i_SelA))
      SRC_RAM:  acc_d = rd;
      SRC_IMM:  acc_d = imm;
      SRC_ALU:  acc_d = alu;
      default:  acc_d = acc_q;  // reserved select holds the accumulator
    endcase

    acc_load = (state_q == RUN) && i_WrAcc && (i_SelA != SRC_NONE);
  end

  // RAM write port: the clear sweep owns it in CLEAR, the store strobe in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = i_Operand;
    mem_wdata = acc_q;
    if (!i_reset) begin
      if (state_q == CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = clr_addr_q;
        mem_wdata = '0;
      end else if (i_WrRam) begin
        mem_we = 1'b1;
      end
    end
  end

  // Sequencer, clear address, accumulator and ready flag.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is what makes a same-cycle store see the
    // old accumulator while the accumulator loads from pre-edge RAM.
    if (i_reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      acc_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == '1) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (acc_load) begin
            acc_q <= acc_d;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Data RAM storage.
  always_ff @(posedge i_clk) begin
    // NOTE: the array has no reset branch so it maps onto RAM macros; the
    // CLEAR sweep provides the zero initial contents instead.
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign o_Acc   = acc_q;
  assign o_Ready = ready_q;

endmodule
